// File: rtl/acp_ram_responder_pkg.sv
// Shared configuration for the ACP RAM responder: FSM encoding and the
// default placement/size of the ACP RAM window.
package acp_ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } acp_state_t;

    localparam logic [31:0] ACP_RAM_BASE  = 32'h0003_0000;
    localparam int          ACP_RAM_WORDS = 32;

endpackage

// File: rtl/acp_ram_responder.sv
// Bridges a valid/ready load/store request port onto a single-port word RAM with range/alignment faulting.
// Latency: store/fault response one cycle after accept, load response two cycles after accept.
// Backpressure: one request in flight; req_ready is low until the response is taken by rsp_ready.
module acp_ram_responder
    import acp_ram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = ACP_RAM_BASE,
    parameter int          WORDS     = ACP_RAM_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic                     req_we,
    input  logic [3:0]               req_be,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     ram_en,
    output logic [3:0]               ram_we,
    output logic [$clog2(WORDS)-1:0] ram_addr,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata,
    output logic [7:0]               err_count
);

    localparam int          AW   = $clog2(WORDS);
    localparam logic [32:0] SPAN = 33'(4 * WORDS);

    acp_state_t  state;
    logic        accept;
    logic        in_range;
    logic [31:0] offset;

    // Subtract first so a window ending at the top of the address space cannot wrap.
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN) &&
                      (req_addr[1:0] == 2'b00);

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready && rst_n;

    assign ram_en    = accept && in_range;
    assign ram_we    = (accept && in_range && req_we) ? req_be : 4'b0000;
    assign ram_addr  = req_addr[2 +: AW];
    assign ram_wdata = req_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else if (req_we) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // RAM data is valid exactly one cycle after the enable.
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ram_rdata;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acp_ram_responder.sv
// Randomized self-checking bench for acp_ram_responder against a word-array reference model.
module tb_acp_ram_responder;

    localparam logic [31:0] BASE  = 32'h0003_0000;
    localparam int          WORDS = 32;
    localparam int          AW    = $clog2(WORDS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_we;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [7:0]    err_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram_mem [WORDS];
    logic [31:0] shadow  [WORDS];
    int          model_errs;

    always #5 clk = ~clk;

    acp_ram_responder #(.BASE_ADDR(BASE), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err_count(err_count)
    );

    // Environment RAM: synchronous read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000)
                ram_rdata <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0, 1:    a = BASE + 4 * $urandom_range(0, WORDS - 1);
            2:       a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
            3:       a = BASE - 4 * $urandom_range(1, 4);
            4:       a = BASE + 4 * WORDS + 4 * $urandom_range(0, 3);
            default: a = BASE + 4 * WORDS - 4;
        endcase
        return a;
    endfunction

    // Issues one request and follows it through to the response handshake.
    // Called between a negedge and the following posedge.
    task automatic txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input int hold, input bit keep,
                       output int waited);
        longint      off;
        bit          ok;
        int          idx;
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] first_data;
        logic        first_err;

        off      = longint'(addr) - longint'(BASE);
        ok       = (off >= 0) && (off < 4 * WORDS) && (addr[1:0] == 2'b00);
        idx      = ok ? int'(off / 4) : 0;
        exp_data = 32'h0;

        req_addr  = addr;
        req_we    = we;
        req_be    = be;
        req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready) check_eq("accept_timeout", {31'b0, req_ready}, 32'h1);

        check_eq("acc_ram_en", {31'b0, ram_en}, {31'b0, ok});
        if (ok && we) begin
            check_eq("acc_ram_we", {28'b0, ram_we}, {28'b0, be});
            check_eq("acc_ram_addr", {{(32-AW){1'b0}}, ram_addr}, 32'(idx));
            check_eq("acc_ram_wdata", ram_wdata, wdata);
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            check_eq("acc_ram_we0", {28'b0, ram_we}, 32'h0);
            if (ok) check_eq("acc_ram_addr", {{(32-AW){1'b0}}, ram_addr}, 32'(idx));
        end
        if (!ok) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
        else if (!we) exp_data = shadow[idx];

        @(negedge clk);
        req_valid = keep;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            check_eq("wait_ram_en", {31'b0, ram_en}, 32'h0);
            @(negedge clk); #1;
            lat++;
        end
        check_eq("rsp_latency", 32'(lat), (ok && !we) ? 32'd2 : 32'd1);
        check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, !ok});
        check_eq("rsp_rdata", rsp_rdata, exp_data);
        check_eq("err_count", {24'b0, err_count}, 32'(model_errs));

        first_data = rsp_rdata;
        first_err  = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check_eq("hold_valid", {31'b0, rsp_valid}, 32'h1);
            check_eq("hold_rdata", rsp_rdata, first_data);
            check_eq("hold_err", {31'b0, rsp_err}, {31'b0, first_err});
            check_eq("hold_req_ready", {31'b0, req_ready}, 32'h0);
            check_eq("hold_ram_en", {31'b0, ram_en}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check_eq("post_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("post_req_ready", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        int w;
        int w2;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        model_errs = 0;
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = $urandom;
            shadow[i]  = ram_mem[i];
        end

        repeat (2) @(negedge clk);
        req_addr  = BASE + 32'h4;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_valid = 1'b1;
        #1;
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err_count", {24'b0, err_count}, 32'h0);
        check_eq("rst_ram_en", {31'b0, ram_en}, 32'h0);
        check_eq("rst_ram_we", {28'b0, ram_we}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(BASE + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, w);
        txn(BASE + 32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);
        check_eq("load_deadbeef", rsp_rdata, 32'hDEAD_BEEF);
        txn(BASE + 32'h80, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);
        txn(BASE - 32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);
        check_eq("err_count_two", {24'b0, err_count}, 32'd2);
        txn(BASE + 32'h2, 1'b0, 4'h0, 32'h0, 1, 1'b0, w);
        txn(BASE + 32'h8, 1'b0, 4'h0, 32'h0, 5, 1'b1, w);
        txn(BASE + 32'hC, 1'b1, 4'h5, $urandom, 0, 1'b0, w2);
        check_eq("b2b_accept_wait", 32'(w2), 32'd0);
        txn(BASE + 32'h10, 1'b1, 4'h0, 32'h1234_5678, 0, 1'b0, w);
        txn(BASE + 32'h10, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);
        txn(BASE + 4 * WORDS - 4, 1'b1, 4'hA, 32'hCAFE_F00D, 0, 1'b0, w);
        txn(BASE + 4 * WORDS - 4, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);

        for (int i = 0; i < 150; i++)
            txn(rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                $urandom_range(0, 2), 1'b0, w);

        for (int i = 0; i < 260; i++)
            txn(BASE + 32'h2, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);
        check_eq("err_count_sat", {24'b0, err_count}, 32'd255);

        req_addr  = BASE + 32'h8;
        req_we    = 1'b0;
        req_valid = 1'b1;
        #1;
        check_eq("rw_accept_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        model_errs = 0;
        #1;
        check_eq("rw_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_eq("rw_rst_err_count", {24'b0, err_count}, 32'h0);
        req_valid = 1'b1;
        #1;
        check_eq("rw_rst_ram_en", {31'b0, ram_en}, 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check_eq("rw_post_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            check_eq("rw_post_req_ready", {31'b0, req_ready}, 32'h1);
        end
        txn(BASE + 32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
